abc: RTL and testbench
======================

ABC -- requirements
Module: abc

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, the width of dataA and dataB.
REQ-002 The block SHALL have parameter LONG_CLK, default 12, the pulse length in clocks when B >= A.
REQ-003 The block SHALL have parameter SHORT_CLK, default 6, the pulse length in clocks when B < A.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port davA_, input, 1 bit: producer A data-valid, active low.
REQ-007 The block SHALL have port rfdA, output, 1 bit: ready-for-data to producer A, active high.
REQ-008 The block SHALL have port dataA, input, DATA_W bits: operand A, unsigned.
REQ-009 The block SHALL have port davB_, input, 1 bit: producer B data-valid, active low.
REQ-010 The block SHALL have port rfdB, output, 1 bit: ready-for-data to producer B, active high.
REQ-011 The block SHALL have port dataB, input, DATA_W bits: operand B, unsigned.
REQ-012 The block SHALL have port out, output, 1 bit: the formed pulse.
REQ-013 All outputs SHALL be registered.

Function
REQ-014 The FSM SHALL have exactly three states: WAIT_DAV, WAIT_RELEASE and PULSE.
REQ-015 WAIT_DAV: rfdA=rfdB=1, out=0; leave only when davA_==0 and davB_==0 are sampled in the same clock.
REQ-016 If only one dav_ is low in WAIT_DAV, the block SHALL keep waiting; producers may assert in any order and at any skew.
REQ-017 On leaving WAIT_DAV, the block SHALL latch dataA and dataB, drive rfdA=rfdB=0 and go to WAIT_RELEASE.
REQ-018 On leaving WAIT_DAV, the block SHALL select N=LONG_CLK if dataB>=dataA (unsigned, equality counts as long), else N=SHORT_CLK.
REQ-019 WAIT_RELEASE: rfd outputs stay 0; when davA_==1 and davB_==1 are sampled together, the block SHALL assert out=1 and go to PULSE.
REQ-020 PULSE: out SHALL stay 1 for exactly N clock periods from its rising edge to its falling edge, with rfdA=rfdB=0.
REQ-021 At the end of PULSE, out SHALL go to 0 and rfdA and rfdB SHALL rise in the same clock; the FSM returns to WAIT_DAV.
REQ-022 out SHALL be low for at least 1 clock between consecutive pulses.
REQ-023 A new operand pair SHALL never be accepted while a pulse is in progress; no buffering.
REQ-024 Changes on dataA/dataB outside the latch clock SHALL NOT affect the pulse length.
REQ-025 The pulse counter SHALL be wide enough for max(LONG_CLK, SHORT_CLK); 4 bits at the defaults.

Reset
REQ-026 While reset_==0 at a rising clock edge: state=WAIT_DAV, out=0, rfdA=1, rfdB=1, counter and latched data cleared.
REQ-027 Reset asserted in any state, including mid-pulse, SHALL abort the operation with the values of REQ-026 on the next edge.
REQ-028 The first clock after reset release SHALL already be in WAIT_DAV.

Structure
REQ-029 Package abc_pkg SHALL hold the state enum (WAIT_DAV, WAIT_RELEASE, PULSE) and the LONG_CLK/SHORT_CLK default constants.
REQ-030 One sub-module, abc_pulse_timer, SHALL exist: load N, count down, assert done; the FSM and handshake logic stay in abc.

Verification
REQ-031 After reset with davA_=davB_=1: out=0, rfdA=1, rfdB=1 at the first falling edge.
REQ-032 A=9, B=5, A handshake 2 clocks before B: rfdA falls only when both dav_ are low; out is high for exactly 6 clocks.
REQ-033 A=2, B=8 -> out is high for exactly 12 clocks; A=B=5 -> out is high for exactly 12 clocks (equality case).
REQ-034 32 back-to-back pairs, a=((i+5)*19%100)/10 and b=((i+5)*19%100)%10: each pulse is 12 clocks if b>=a, else 6, and no pair is lost or duplicated.
REQ-035 reset_=0 for 1 clock during the 4th clock of a 12-clock pulse: out=0 and rfdA=rfdB=1 next clock, then the next full handshake yields a correct pulse.
REQ-036 dataA changes while in WAIT_RELEASE -> pulse length follows the latched values.

Source files
------------

// File: rtl/abc_pkg.sv
// ----------------------------------------------------------------------------
// abc_pkg
// Shared definitions for the two-producer pulse former:
//   state_t        - controller state encoding
//   LONG_CLK_DEF   - default pulse length when B >= A
//   SHORT_CLK_DEF  - default pulse length when B < A
//   cnt_width()    - pulse counter width able to hold the longer length
// ----------------------------------------------------------------------------
package abc_pkg;

    typedef enum logic [1:0] {
        WAIT_DAV     = 2'd0,
        WAIT_RELEASE = 2'd1,
        PULSE        = 2'd2
    } state_t;

    localparam int LONG_CLK_DEF  = 12;
    localparam int SHORT_CLK_DEF = 6;

    function automatic int cnt_width(input int long_clk, input int short_clk);
        int longest;
        longest = (long_clk > short_clk) ? long_clk : short_clk;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/abc_pulse_timer.sv
// ----------------------------------------------------------------------------
// abc_pulse_timer
// Down-counter that times the output pulse. Loaded with the pulse length N
// on the clock the pulse starts; done flags the last clock of the pulse.
// Ports:
//   clock    - rising-edge clock
//   reset_   - synchronous active-low reset
//   load     - load load_val into the counter
//   load_val - pulse length in clocks (>= 1)
//   run      - count down while high
//   done     - high during the final clock of a running pulse
// ----------------------------------------------------------------------------
module abc_pulse_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             run,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (run && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    // Loaded with N at the rising edge of out, so the count reaches 1 exactly
    // N-1 clocks later; the falling edge of out then lands N clocks after the rise.
    assign done = run && (count == CNT_W'(1));

endmodule

// File: rtl/abc.sv
// ----------------------------------------------------------------------------
// abc
// Pulse former with a two-producer handshake. Once both producers assert
// data-valid in the same clock, the operands are latched, both producers are
// released, and a pulse of LONG_CLK clocks (B >= A) or SHORT_CLK clocks
// (B < A) is emitted.
// Ports:
//   clock        - rising-edge clock
//   reset_       - synchronous active-low reset
//   davA_, davB_ - producer data-valid, active low
//   rfdA, rfdB   - ready-for-data to the producers, active high
//   dataA, dataB - unsigned operands
//   out          - formed pulse
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   WAIT_DAV     | rfd high, waiting for both dav_ low in the same clock
//   WAIT_RELEASE | operands latched, rfd low, waiting for both dav_ high
//   PULSE        | out high for N clocks, then rfd rises and out falls
// ----------------------------------------------------------------------------
module abc
    import abc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LONG_CLK  = LONG_CLK_DEF,
    parameter int SHORT_CLK = SHORT_CLK_DEF
) (
    input  logic              clock,
    input  logic              reset_,
    input  logic              davA_,
    output logic              rfdA,
    input  logic [DATA_W-1:0] dataA,
    input  logic              davB_,
    output logic              rfdB,
    input  logic [DATA_W-1:0] dataB,
    output logic              out
);

    localparam int CNT_W = cnt_width(LONG_CLK, SHORT_CLK);

    state_t            state, state_nx;
    logic              rfd, rfd_nx;
    logic              out_nx;
    logic [DATA_W-1:0] data_a_q, data_a_nx;
    logic [DATA_W-1:0] data_b_q, data_b_nx;
    logic              load;
    logic              run;
    logic              done;
    logic [CNT_W-1:0]  len;

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state    <= WAIT_DAV;
            rfd      <= 1'b1;
            out      <= 1'b0;
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            state    <= state_nx;
            rfd      <= rfd_nx;
            out      <= out_nx;
            data_a_q <= data_a_nx;
            data_b_q <= data_b_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        rfd_nx    = rfd;
        out_nx    = out;
        data_a_nx = data_a_q;
        data_b_nx = data_b_q;
        load      = 1'b0;
        case (state)
            WAIT_DAV: begin
                rfd_nx = 1'b1;
                out_nx = 1'b0;
                if (!davA_ && !davB_) begin
                    data_a_nx = dataA;
                    data_b_nx = dataB;
                    rfd_nx    = 1'b0;
                    state_nx  = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                rfd_nx = 1'b0;
                if (davA_ && davB_) begin
                    out_nx   = 1'b1;
                    load     = 1'b1;
                    state_nx = PULSE;
                end
            end
            PULSE: begin
                if (done) begin
                    out_nx   = 1'b0;
                    rfd_nx   = 1'b1;
                    state_nx = WAIT_DAV;
                end
            end
            default: begin
                state_nx = WAIT_DAV;
                rfd_nx   = 1'b1;
                out_nx   = 1'b0;
            end
        endcase
    end

    // Length comes from the latched operands only, so later activity on
    // dataA/dataB cannot alter a pulse already committed.
    assign len = (data_b_q >= data_a_q) ? CNT_W'(LONG_CLK) : CNT_W'(SHORT_CLK);
    assign run = (state == PULSE);

    abc_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock    (clock),
        .reset_   (reset_),
        .load     (load),
        .load_val (len),
        .run      (run),
        .done     (done)
    );

    assign rfdA = rfd;
    assign rfdB = rfd;

endmodule

// File: tb/tb_abc.sv
module tb_abc;

    localparam int DATA_W = 8;
    localparam int LONG   = 12;
    localparam int SHORT  = 6;

    logic              clock = 1'b0;
    logic              reset_;
    logic              davA_, davB_;
    logic              rfdA, rfdB;
    logic [DATA_W-1:0] dataA, dataB;
    logic              out;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int pairs_issued = 0;
    int pulses_seen = 0;
    int mon_len = 0;
    int exp_q[$];

    abc #(
        .DATA_W    (DATA_W),
        .LONG_CLK  (LONG),
        .SHORT_CLK (SHORT)
    ) dut (
        .clock  (clock),
        .reset_ (reset_),
        .davA_  (davA_),
        .rfdA   (rfdA),
        .dataA  (dataA),
        .davB_  (davB_),
        .rfdB   (rfdB),
        .dataB  (dataB),
        .out    (out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rule: unsigned compare, equality selects the long pulse.
    function automatic int model_len(input int a, input int b);
        return (b >= a) ? LONG : SHORT;
    endfunction

    // Monitor: measures each pulse of out and compares against the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (out === 1'b1) begin
                mon_len++;
                check("rfd_low_during_pulse", 32'({rfdA, rfdB}), 32'd0);
            end else if (mon_len > 0) begin
                check("rfd_high_after_pulse", 32'({rfdA, rfdB}), 32'd3);
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse_len", 32'(mon_len), 32'd0);
                end else begin
                    check("pulse_len", 32'(mon_len), 32'(exp_q.pop_front()));
                end
                pulses_seen++;
                mon_len = 0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clock);
        while (!(rfdA === 1'b1 && rfdB === 1'b1) && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("rfd_ready_wait", 32'({rfdA, rfdB}), 32'd3);
    endtask

    // One complete handshake. exp_override > 0 replaces the model length
    // (used when the pulse will be cut short by reset).
    task automatic do_pair(input int a, input int b, input int skew, input bit b_first,
                           input bit wiggle, input int exp_override);
        wait_ready();
        if (skew > 0) begin
            if (!b_first) begin
                dataA = DATA_W'(a);
                davA_ = 1'b0;
            end else begin
                dataB = DATA_W'(b);
                davB_ = 1'b0;
            end
            repeat (skew) begin
                @(negedge clock);
                check("rfd_hold_single_dav", 32'({rfdA, rfdB}), 32'd3);
            end
        end
        dataA = DATA_W'(a);
        dataB = DATA_W'(b);
        davA_ = 1'b0;
        davB_ = 1'b0;
        exp_q.push_back((exp_override > 0) ? exp_override : model_len(a, b));
        pairs_issued++;
        @(negedge clock);
        check("rfd_fall_on_accept", 32'({rfdA, rfdB}), 32'd0);
        davA_ = 1'b1;
        davB_ = 1'b1;
        if (wiggle) begin
            dataA = DATA_W'($urandom);
            dataB = DATA_W'($urandom);
        end
    endtask

    initial begin
        int n;
        int a;
        int b;
        reset_ = 1'b0;
        davA_  = 1'b1;
        davB_  = 1'b1;
        dataA  = '0;
        dataB  = '0;
        repeat (3) @(negedge clock);
        check("reset_out", 32'(out), 32'd0);
        check("reset_rfd", 32'({rfdA, rfdB}), 32'd3);
        reset_ = 1'b1;
        @(negedge clock);
        check("post_reset_out", 32'(out), 32'd0);
        check("post_reset_rfd", 32'({rfdA, rfdB}), 32'd3);

        // A first by 2 clocks, B < A -> short pulse
        do_pair(9, 5, 2, 1'b0, 1'b0, 0);
        // B >= A and equality -> long pulse
        do_pair(2, 8, 0, 1'b0, 1'b0, 0);
        do_pair(5, 5, 1, 1'b1, 1'b0, 0);

        // back-to-back digit pairs
        for (int i = 0; i < 32; i++) begin
            a = (((i + 5) * 19) % 100) / 10;
            b = (((i + 5) * 19) % 100) % 10;
            do_pair(a, b, 0, 1'b0, 1'b0, 0);
        end

        // reset during the 4th clock of a 12-clock pulse
        do_pair(2, 8, 0, 1'b0, 1'b0, 4);
        n = 0;
        while (out !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("abort_pulse_started", 32'(out), 32'd1);
        repeat (3) @(negedge clock);
        reset_ = 1'b0;
        @(negedge clock);
        reset_ = 1'b1;
        check("abort_out", 32'(out), 32'd0);
        check("abort_rfd", 32'({rfdA, rfdB}), 32'd3);
        do_pair(7, 7, 0, 1'b0, 1'b0, 0);
        do_pair(200, 3, 0, 1'b0, 1'b0, 0);

        // operands change after latching
        do_pair(3, 200, 0, 1'b0, 1'b1, 0);
        dataA = 8'd255;
        do_pair(200, 3, 1, 1'b1, 1'b1, 0);
        dataA = 8'd0;
        dataB = 8'd255;

        // randomized pairs, skews and orderings
        for (int i = 0; i < 24; i++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 3) == 0) ? a : int'($urandom_range(0, 255));
            do_pair(a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 0);
        end

        n = 0;
        while ((exp_q.size() != 0 || out === 1'b1) && n < 200) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("pulse_count", 32'(pulses_seen), 32'(pairs_issued));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
